// File: rtl/fop_pkg.sv
// Shared definitions for the 8-bit floating-point opcode encoder.
// Class codes, per-class opcode windows and the encode helper.
package fop_pkg;

  localparam int FOP_CLS_W = 4;
  localparam int FOP_IDX_W = 5;

  typedef enum logic [FOP_CLS_W-1:0] {
    SWAP_R = 4'd0,
    ADD_R  = 4'd1,
    ADD_M  = 4'd2,
    SUB_R  = 4'd3,
    SUB_M  = 4'd4,
    SCAL_R = 4'd5,
    MUL_R  = 4'd6,
    DIV_M  = 4'd7,
    SQRT_R = 4'd8
  } fop_cls_t;

  localparam logic [7:0] SWAP_R_BASE = 8'h78;
  localparam logic [7:0] ADD_R_BASE  = 8'h7C;
  localparam logic [7:0] ADD_M_BASE  = 8'h8C;
  localparam logic [7:0] SUB_R_BASE  = 8'h91;
  localparam logic [7:0] SUB_M_BASE  = 8'hA1;
  localparam logic [7:0] SCAL_R_BASE = 8'hA6;
  localparam logic [7:0] MUL_R_BASE  = 8'hAC;
  localparam logic [7:0] DIV_M_BASE  = 8'hCC;
  localparam logic [7:0] SQRT_R_BASE = 8'hD0;

  localparam logic [5:0] SWAP_R_SIZE = 6'd4;
  localparam logic [5:0] ADD_R_SIZE  = 6'd16;
  localparam logic [5:0] ADD_M_SIZE  = 6'd5;
  localparam logic [5:0] SUB_R_SIZE  = 6'd16;
  localparam logic [5:0] SUB_M_SIZE  = 6'd5;
  localparam logic [5:0] SCAL_R_SIZE = 6'd6;
  localparam logic [5:0] MUL_R_SIZE  = 6'd32;
  localparam logic [5:0] DIV_M_SIZE  = 6'd4;
  localparam logic [5:0] SQRT_R_SIZE = 6'd6;

  // Returns {err, op}; a zero size marks an illegal class.
  function automatic logic [8:0] fop_encode(
    input logic [FOP_CLS_W-1:0] cls,
    input logic [FOP_IDX_W-1:0] idx
  );
    logic [7:0] base;
    logic [5:0] size;
    base = 8'h00;
    size = 6'd0;
    case (cls)
      SWAP_R: begin base = SWAP_R_BASE; size = SWAP_R_SIZE; end
      ADD_R:  begin base = ADD_R_BASE;  size = ADD_R_SIZE;  end
      ADD_M:  begin base = ADD_M_BASE;  size = ADD_M_SIZE;  end
      SUB_R:  begin base = SUB_R_BASE;  size = SUB_R_SIZE;  end
      SUB_M:  begin base = SUB_M_BASE;  size = SUB_M_SIZE;  end
      SCAL_R: begin base = SCAL_R_BASE; size = SCAL_R_SIZE; end
      MUL_R:  begin base = MUL_R_BASE;  size = MUL_R_SIZE;  end
      DIV_M:  begin base = DIV_M_BASE;  size = DIV_M_SIZE;  end
      SQRT_R: begin base = SQRT_R_BASE; size = SQRT_R_SIZE; end
      default: begin base = 8'h00; size = 6'd0; end
    endcase
    if ({1'b0, idx} < size)
      fop_encode = {1'b0, base + {3'b000, idx}};
    else
      fop_encode = {1'b1, 8'h00};
  endfunction

endpackage

// File: rtl/fop_fifo2.sv
// Two-entry valid/ready FIFO with registered head output.
// Full-state push is allowed when the head pops in the same cycle.
module fop_fifo2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push_v,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_v,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign pop_v      = (count != 2'd0);
  assign push_ready = (count < 2'd2) | ((count == 2'd2) & pop_ready);
  assign push       = push_v & push_ready;
  assign pop        = pop_v & pop_ready;
  assign pop_data   = mem[rptr];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop)
        rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/float_op_encode.sv
// Float opcode encoder: request -> {err, op} -> 2-entry output queue,
// with saturating counts of legal and error entries leaving the queue.
module float_op_encode
  import fop_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 req_v_i,
  output logic                 req_ready_o,
  input  logic [FOP_CLS_W-1:0] req_cls_i,
  input  logic [FOP_IDX_W-1:0] req_idx_i,
  output logic                 op_v_o,
  input  logic                 op_ready_i,
  output logic [7:0]           op_o,
  output logic                 op_err_o,
  output logic [CNT_W-1:0]     cnt_op_o,
  output logic [CNT_W-1:0]     cnt_err_o
);

  logic [8:0] enc;
  logic [8:0] head;
  logic       pop;

  assign enc = fop_encode(req_cls_i, req_idx_i);

  fop_fifo2 #(.W(9)) u_fifo (
    .clk        (clk),
    .nreset     (nreset),
    .push_v     (req_v_i),
    .push_ready (req_ready_o),
    .push_data  (enc),
    .pop_v      (op_v_o),
    .pop_ready  (op_ready_i),
    .pop_data   (head)
  );

  assign op_err_o = head[8];
  assign op_o     = head[7:0];
  assign pop      = op_v_o & op_ready_i;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_op_o  <= '0;
      cnt_err_o <= '0;
    end else if (pop) begin
      if (!op_err_o && cnt_op_o != '1)
        cnt_op_o <= cnt_op_o + 1'b1;
      if (op_err_o && cnt_err_o != '1)
        cnt_err_o <= cnt_err_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_float_op_encode.sv
// Scoreboard bench for float_op_encode: driver pushes expectations,
// a negedge monitor pops and compares on every output handshake.
module tb_float_op_encode;

  localparam int CW  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          req_v_i = 1'b0;
  logic          req_ready_o;
  logic [3:0]    req_cls_i = '0;
  logic [4:0]    req_idx_i = '0;
  logic          op_v_o;
  logic          op_ready_i = 1'b1;
  logic [7:0]    op_o;
  logic          op_err_o;
  logic [CW-1:0] cnt_op_o;
  logic [CW-1:0] cnt_err_o;

  float_op_encode #(.CNT_W(CW)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .req_v_i     (req_v_i),
    .req_ready_o (req_ready_o),
    .req_cls_i   (req_cls_i),
    .req_idx_i   (req_idx_i),
    .op_v_o      (op_v_o),
    .op_ready_i  (op_ready_i),
    .op_o        (op_o),
    .op_err_o    (op_err_o),
    .cnt_op_o    (cnt_op_o),
    .cnt_err_o   (cnt_err_o)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int m_op = 0;
  int m_err = 0;
  logic [8:0] sb[$];

  int base_t[9] = '{120, 124, 140, 145, 161, 166, 172, 204, 208};
  int size_t[9] = '{4, 16, 5, 16, 5, 6, 32, 4, 6};

  function automatic logic [8:0] model(int cls, int idx);
    int v;
    if (cls < 9 && idx < size_t[cls]) begin
      v = base_t[cls] + idx;
      return {1'b0, v[7:0]};
    end
    return 9'h100;
  endfunction

  function automatic void chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    logic [8:0] e;
    if (nreset) begin
      chk("cnt_op", int'(cnt_op_o), m_op);
      chk("cnt_err", int'(cnt_err_o), m_err);
      if (op_v_o && op_ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("op", int'(op_o), int'(e[7:0]));
          chk("err", int'(op_err_o), int'(e[8]));
          if (e[8]) m_err = (m_err < MAX) ? m_err + 1 : MAX;
          else      m_op  = (m_op  < MAX) ? m_op  + 1 : MAX;
        end
      end
    end
  end

  task automatic send(int cls, int idx);
    int n = 0;
    bit done = 0;
    req_v_i = 1'b1;
    req_cls_i = cls[3:0];
    req_idx_i = idx[4:0];
    while (!done && n < 200) begin
      @(negedge clk);
      if (req_ready_o) begin
        sb.push_back(model(cls, idx));
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    req_v_i = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    op_ready_i = 1'b1;
    while ((sb.size() != 0 || op_v_o) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    nreset = 1'b0;
    req_v_i = 1'b0;
    #1;
    chk("rst_op_v", int'(op_v_o), 0);
    chk("rst_cnt_op", int'(cnt_op_o), 0);
    chk("rst_cnt_err", int'(cnt_err_o), 0);
    chk("rst_op", int'(op_o), 0);
    chk("rst_op_err", int'(op_err_o), 0);
    chk("rst_ready", int'(req_ready_o), 1);
    sb.delete();
    m_op = 0;
    m_err = 0;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pat[6][2] = '{'{1, 0}, '{1, 4}, '{3, 15}, '{6, 31}, '{8, 5}, '{0, 3}};
    do_reset();

    // Latency: empty before accept, valid right after the accept edge
    chk("empty_before", int'(op_v_o), 0);
    send(1, 0);
    chk("latency_v", int'(op_v_o), 1);
    chk("latency_op", int'(op_o), 8'h7C);
    for (int i = 1; i < 6; i++) send(pat[i][0], pat[i][1]);
    drain();

    do_reset();
    send(8, 6);
    send(12, 0);
    drain();
    chk("err_cnt2", int'(cnt_err_o), 2);
    chk("err_cnt_op0", int'(cnt_op_o), 0);

    // Backpressure: fill, hold third request, then release
    do_reset();
    op_ready_i = 1'b0;
    send(7, 0);
    send(7, 3);
    fork
      send(7, 1);
    join_none
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", int'(req_ready_o), 0);
      chk("bp_head", int'(op_o), 8'hCC);
      chk("bp_v", int'(op_v_o), 1);
    end
    @(posedge clk);
    #1;
    op_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_full_ready", int'(req_ready_o), 1);
    wait fork;
    drain();

    // Full queue with alternating downstream ready
    do_reset();
    op_ready_i = 1'b0;
    send(6, 1);
    send(6, 2);
    fork
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        op_ready_i = ~op_ready_i;
      end
    join_none
    for (int i = 0; i < 10; i++) send(6, 3 + i);
    wait fork;
    drain();

    // Reset with entries queued
    op_ready_i = 1'b0;
    send(2, 1);
    send(2, 2);
    do_reset();
    op_ready_i = 1'b1;
    chk("post_rst_ready", int'(req_ready_o), 1);
    send(5, 2);
    chk("post_rst_latency", int'(op_v_o), 1);
    drain();

    // Saturation of the legal counter
    do_reset();
    for (int i = 0; i < 5; i++) send(4, i % 5);
    drain();
    chk("sat_cnt_op", int'(cnt_op_o), MAX);

    // Randomised traffic
    do_reset();
    fork
      for (int i = 0; i < 150; i++) begin
        @(posedge clk);
        #1;
        op_ready_i = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 60; i++)
      send($urandom_range(0, 15), $urandom_range(0, 31));
    wait fork;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
